// File: rtl/rotating_pattern_disp.sv
// -----------------------------------------------------------------------------
// rotating_pattern_disp
//   Animates square glyphs across N_DIGITS multiplexed seven-segment digits.
//   Four animation modes (circulate, marquee, bounce, blank) with a selectable
//   step speed, direction and pause. Contains its own step prescaler and a
//   digit-refresh multiplexer that keeps scanning regardless of en/mode.
//
// Ports
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   en     in   1 = animation advances, 0 = pause (refresh continues)
//   cw     in   circulate direction: 1 = increment pos, 0 = decrement pos
//   mode   in   0 circulate, 1 marquee, 2 bounce, 3 blank
//   speed  in   step period = ROT_PERIOD >> speed
//   sseg   out  segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   an     out  digit enables, active-low one-hot, registered (MSB = leftmost)
// -----------------------------------------------------------------------------
module rotating_pattern_disp #(
  parameter int N_DIGITS   = 4,
  parameter int ROT_PERIOD = 25_000_000,
  parameter int MUX_PERIOD = 50_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cw,
  input  logic [1:0]          mode,
  input  logic [1:0]          speed,
  output logic [7:0]          sseg,
  output logic [N_DIGITS-1:0] an
);

  localparam int PS_W  = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;
  localparam int MUX_W = (MUX_PERIOD > 1) ? $clog2(MUX_PERIOD) : 1;
  localparam int POS_W = $clog2(2 * N_DIGITS);
  localparam int IDX_W = $clog2(N_DIGITS);

  localparam logic [7:0] UPPER = 8'h9C;
  localparam logic [7:0] LOWER = 8'hA3;
  localparam logic [7:0] BLANK = 8'hFF;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(2 * N_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
  localparam logic [MUX_W-1:0] MUX_MAX = MUX_W'(MUX_PERIOD - 1);

  typedef enum logic [1:0] {
    MODE_CIRC   = 2'd0,
    MODE_MARQ   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Pattern / prescaler state and next-state
  logic [PS_W-1:0]  ps_cnt, ps_cnt_n;
  logic [POS_W-1:0] pos, pos_n;
  logic             phase, phase_n;
  logic [IDX_W-1:0] b, b_n;
  dir_e             dir, dir_n;

  // Refresh multiplexer
  logic [MUX_W-1:0] mux_cnt;
  logic [IDX_W-1:0] idx;

  logic [1:0]  mode_q;
  mode_e       mode_cur;
  logic        mode_chg;
  logic [31:0] step_period;
  logic        tick;
  logic        step;
  logic [7:0]  glyph;

  assign mode_cur = mode_e'(mode);

  // Previous-cycle mode. Deliberately follows mode during reset too, so the
  // first cycle after release never sees a spurious mode change.
  always_ff @(posedge clk) begin
    mode_q <= mode;
  end

  assign mode_chg = (mode != mode_q);

  // Full 32-bit period so ROT_PERIOD >> 3 is never truncated; comparing
  // count+1 against the period avoids underflow when the period is 0 or 1.
  assign step_period = 32'(ROT_PERIOD) >> speed;
  assign tick        = en && ((32'(ps_cnt) + 32'd1) >= step_period);
  assign step        = tick && !mode_chg;   // mode change drops the step

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ps_cnt_n = ps_cnt;
    pos_n    = pos;
    phase_n  = phase;
    b_n      = b;
    dir_n    = dir;

    if (mode_chg) begin
      ps_cnt_n = '0;
      pos_n    = '0;
      phase_n  = 1'b0;
      b_n      = '0;
      dir_n    = DIR_UP;
    end else begin
      if (en) begin
        ps_cnt_n = tick ? '0 : ps_cnt + PS_W'(1);
      end
      if (step) begin
        unique case (mode_cur)
          MODE_CIRC: begin
            if (cw) pos_n = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
            else    pos_n = (pos == '0) ? POS_MAX : pos - POS_W'(1);
          end
          MODE_MARQ: phase_n = ~phase;
          MODE_BOUNCE: begin
            // Reversal happens on the step taken at an end: no dwell.
            if (dir == DIR_UP) begin
              if (b == IDX_MAX) begin
                dir_n = DIR_DOWN;
                b_n   = IDX_MAX - IDX_W'(1);
              end else begin
                b_n = b + IDX_W'(1);
              end
            end else begin
              if (b == '0) begin
                dir_n = DIR_UP;
                b_n   = IDX_W'(1);
              end else begin
                b_n = b - IDX_W'(1);
              end
            end
          end
          MODE_BLANK: ;
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_cnt <= '0;
      pos    <= '0;
      phase  <= 1'b0;
      b      <= '0;
      dir    <= DIR_UP;
    end else begin
      ps_cnt <= ps_cnt_n;
      pos    <= pos_n;
      phase  <= phase_n;
      b      <= b_n;
      dir    <= dir_n;
    end
  end

  // Digit refresh: independent of en and mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mux_cnt <= '0;
      idx     <= '0;
    end else if (mux_cnt == MUX_MAX) begin
      mux_cnt <= '0;
      idx     <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end else begin
      mux_cnt <= mux_cnt + MUX_W'(1);
    end
  end

  // Glyph for the currently selected digit.
  always_comb begin
    glyph = BLANK;
    unique case (mode_cur)
      MODE_CIRC: begin
        if (int'(pos) < N_DIGITS) begin
          if (int'(idx) == N_DIGITS - 1 - int'(pos)) glyph = UPPER;
        end else begin
          if (int'(idx) == int'(pos) - N_DIGITS) glyph = LOWER;
        end
      end
      MODE_MARQ:   glyph = ((idx[0] ^ phase) == 1'b0) ? UPPER : LOWER;
      MODE_BOUNCE: glyph = (idx == b) ? UPPER : BLANK;
      MODE_BLANK:  glyph = BLANK;
      default:     glyph = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sseg <= BLANK;
      an   <= '1;
    end else begin
      sseg <= glyph;
      an   <= ~(N_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_rotating_pattern_disp.sv
// -----------------------------------------------------------------------------
// tb_rotating_pattern_disp
//   Self-checking bench for rotating_pattern_disp (N_DIGITS=4, ROT_PERIOD=8,
//   MUX_PERIOD=2). A behavioural model tracks elapsed enabled cycles, total
//   step counts and a triangle-wave bounce index, and predicts sseg/an every
//   clock. Directed steps follow the plan, then a randomized run.
// -----------------------------------------------------------------------------
module tb_rotating_pattern_disp;

  localparam int N   = 4;
  localparam int ROT = 8;
  localparam int MUX = 2;

  localparam logic [7:0] UP = 8'h9C;
  localparam logic [7:0] LO = 8'hA3;
  localparam logic [7:0] BL = 8'hFF;

  logic         clk = 1'b0;
  logic         rst_n, en, cw;
  logic [1:0]   mode, speed;
  logic [7:0]   sseg;
  logic [N-1:0] an;

  rotating_pattern_disp #(
    .N_DIGITS  (N),
    .ROT_PERIOD(ROT),
    .MUX_PERIOD(MUX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .cw   (cw),
    .mode (mode),
    .speed(speed),
    .sseg (sseg),
    .an   (an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: plain integers, not the DUT's encoding.
  int m_cnt;        // enabled cycles since last step
  int m_mux;        // cycles on the current digit
  int m_digit;      // selected digit
  int m_pos;        // circulate position 0..2N-1
  int m_phase;      // marquee steps modulo 2
  int m_bk;         // bounce steps modulo 2N-2 (triangle-wave phase)
  int m_prev_mode;
  logic [7:0]   exp_sseg;
  logic [N-1:0] exp_an;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_glyph(input int md, input int d);
    int bpos;
    case (md)
      0: begin
        if (m_pos < N) return (d == N - 1 - m_pos) ? UP : BL;
        else           return (d == m_pos - N)     ? LO : BL;
      end
      1: return (((d % 2) ^ m_phase) == 0) ? UP : LO;
      2: begin
        bpos = (m_bk < N) ? m_bk : (2 * N - 2 - m_bk);
        return (d == bpos) ? UP : BL;
      end
      default: return BL;
    endcase
  endfunction

  // Predict the outputs of the coming edge, advance the model, clock the DUT,
  // then compare away from the edge.
  task automatic cycle();
    int md;
    md = int'(mode);
    if (!rst_n) begin
      exp_sseg    = BL;
      exp_an      = '1;
      m_cnt       = 0;
      m_mux       = 0;
      m_digit     = 0;
      m_pos       = 0;
      m_phase     = 0;
      m_bk        = 0;
    end else begin
      exp_sseg = model_glyph(md, m_digit);
      exp_an   = ~(N'(1) << m_digit);
      if (md != m_prev_mode) begin
        m_cnt   = 0;
        m_pos   = 0;
        m_phase = 0;
        m_bk    = 0;
      end else if (en) begin
        if (m_cnt >= (ROT >> speed) - 1) begin
          m_cnt = 0;
          case (md)
            0: m_pos = cw ? (m_pos + 1) % (2 * N) : (m_pos + 2 * N - 1) % (2 * N);
            1: m_phase = 1 - m_phase;
            2: m_bk = (m_bk + 1) % (2 * N - 2);
            default: ;
          endcase
        end else begin
          m_cnt++;
        end
      end
      m_mux++;
      if (m_mux == MUX) begin
        m_mux   = 0;
        m_digit = (m_digit + 1) % N;
      end
    end
    m_prev_mode = md;
    @(posedge clk);
    #1;
    cyc++;
    check($sformatf("sseg@%0d", cyc), 32'(sseg), 32'(exp_sseg));
    check($sformatf("an@%0d", cyc), 32'(an), 32'(exp_an));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 2'd0;
    cw    = 1'b1;
    speed = 2'd0;
    m_prev_mode = 0;

    // 1. Reset, then first scan of the circulate pattern.
    run(3);
    rst_n = 1'b1;
    cycle();
    check("post_reset_an", 32'(an), 32'h0E);
    check("post_reset_sseg", 32'(sseg), 32'hFF);
    run(6);
    check("digit3_upper_an", 32'(an), 32'h07);
    check("digit3_upper_sseg", 32'(sseg), 32'h9C);

    // 2. Circulate cw through a full lap, then reverse at pos=0.
    run(57);
    cw = 1'b0;
    run(15);
    check("ccw_digit3_an", 32'(an), 32'h07);
    check("ccw_digit3_sseg", 32'(sseg), 32'hA3);

    // 3. Pause mid-count, then resume.
    run(6);
    en = 1'b0;
    run(40);
    en = 1'b1;
    run(12);

    // 4. Fastest speed, then a speed change below the current count.
    speed = 2'd3;
    run(20);
    speed = 2'd0;
    run(6);
    speed = 2'd1;
    run(10);
    speed = 2'd0;

    // 5. Marquee.
    mode = 2'd1;
    run(24);

    // 6. Bounce, blank, bounce again, reset mid-run.
    mode = 2'd2;
    run(80);
    mode = 2'd3;
    run(16);
    mode = 2'd2;
    run(30);
    rst_n = 1'b0;
    cycle();
    check("mid_reset_sseg", 32'(sseg), 32'hFF);
    check("mid_reset_an", 32'(an), 32'h0F);
    rst_n = 1'b1;
    run(20);

    // Randomized run: inputs change occasionally so patterns have time to show.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en    = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) cw    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) mode  = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
